audio_ram_arbiter: RTL and testbench

// Shares the single-port 16-bit ADPCM/CDDA buffer RAM between NUM_REQ requesters: audio decoder reads (idx 0),
// CD sector writer (idx 1), CPU bus accesses (idx 2). Sits between the requesters and the RAM macro.

---
 rtl/audio_mem_pkg.sv | 22 ++
 rtl/arb_priority_sel.sv | 32 +++
 rtl/audio_ram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_audio_ram_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_mem_pkg.sv
// Shared types for the audio buffer RAM arbiter.
// State encoding and the latched request bundle.
package audio_mem_pkg;

  localparam int AUDIO_RAM_ADDR_W = 13;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } arb_state_e;

  typedef struct packed {
    logic                        rd;
    logic                        wr;
    logic [AUDIO_RAM_ADDR_W-1:0] addr;
    logic [15:0]                 wdata;
    logic [1:0]                  be;
  } mem_req_s;

endpackage

// File: rtl/arb_priority_sel.sv
// Combinational winner pick: starved requesters first,
// lowest index wins inside each class.
module arb_priority_sel #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_pending,
  input  logic [N-1:0]  i_starved,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [N-1:0] w_mask;

  always_comb begin
    w_mask = (|(i_pending & i_starved)) ?
             (i_pending & i_starved) : i_pending;
    o_onehot = '0;
    o_idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_mask[i]) begin
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
        o_idx       = IW'(i);
      end
    end
  end

  assign o_valid = |i_pending;

endmodule

// File: rtl/audio_ram_arbiter.sv
// Single-port audio buffer RAM arbiter: fixed priority
// with starvation aging and registered ack/ack_q pulses.
module audio_ram_arbiter
  import audio_mem_pkg::*;
#(
  parameter  int NUM_REQ      = 3,
  parameter  int ADDR_W       = AUDIO_RAM_ADDR_W,
  parameter  int RAM_LATENCY  = 2,
  parameter  int STARVE_LIMIT = 8,
  localparam int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [NUM_REQ-1:0]               i_req_rd,
  input  logic [NUM_REQ-1:0]               i_req_wr,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]   i_req_addr,
  input  logic [NUM_REQ-1:0][15:0]         i_req_wdata,
  input  logic [NUM_REQ-1:0][1:0]          i_req_be,
  output logic [NUM_REQ-1:0]               o_ack,
  output logic [NUM_REQ-1:0]               o_ack_q,
  output logic [NUM_REQ-1:0][15:0]         o_rdata,
  output logic [ADDR_W-1:0]                o_ram_addr,
  output logic                             o_ram_rd,
  output logic                             o_ram_wr,
  output logic [15:0]                      o_ram_wdata,
  output logic [1:0]                       o_ram_be,
  input  logic [15:0]                      i_ram_rdata,
  output logic                             o_busy,
  output logic [IDX_W-1:0]                 o_grant_idx
);

  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam int WAIT_W = $clog2(RAM_LATENCY + 1);

  logic [NUM_REQ-1:0]            w_pending;
  logic [NUM_REQ-1:0]            w_starved;
  logic [NUM_REQ-1:0]            w_onehot;
  logic [IDX_W-1:0]              w_idx;
  logic                          w_valid;
  mem_req_s                      w_sel;

  arb_state_e                    r_state;
  logic                          r_is_wr;
  logic [WAIT_W-1:0]             r_wait;
  logic [NUM_REQ-1:0][CNT_W-1:0] r_starve;
  logic [NUM_REQ-1:0]            r_ack;
  logic [NUM_REQ-1:0]            r_ack_q;
  logic [NUM_REQ-1:0][15:0]      r_rdata;
  logic [ADDR_W-1:0]             r_ram_addr;
  logic                          r_ram_rd;
  logic                          r_ram_wr;
  logic [15:0]                   r_ram_wdata;
  logic [1:0]                    r_ram_be;
  logic                          r_busy;
  logic [IDX_W-1:0]              r_grant_idx;

  assign w_pending = i_req_rd | i_req_wr;

  always_comb begin
    w_starved = '0;
    for (int i = 0; i < NUM_REQ; i++)
      w_starved[i] = (r_starve[i] == CNT_W'(STARVE_LIMIT));
  end

  arb_priority_sel #(
    .N (NUM_REQ)
  ) u_sel (
    .i_pending (w_pending),
    .i_starved (w_starved),
    .o_onehot  (w_onehot),
    .o_idx     (w_idx),
    .o_valid   (w_valid)
  );

  always_comb begin
    w_sel       = '0;
    w_sel.rd    = i_req_rd[w_idx];
    w_sel.wr    = i_req_wr[w_idx];
    w_sel.addr  = AUDIO_RAM_ADDR_W'(i_req_addr[w_idx]);
    w_sel.wdata = i_req_wdata[w_idx];
    w_sel.be    = i_req_be[w_idx];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_is_wr     <= 1'b0;
      r_wait      <= '0;
      r_starve    <= '0;
      r_ack       <= '0;
      r_ack_q     <= '0;
      r_rdata     <= '0;
      r_ram_addr  <= '0;
      r_ram_rd    <= 1'b0;
      r_ram_wr    <= 1'b0;
      r_ram_wdata <= '0;
      r_ram_be    <= '0;
      r_busy      <= 1'b0;
      r_grant_idx <= '0;
    end else begin
      r_ack    <= '0;
      r_ack_q  <= r_ack;
      r_ram_rd <= 1'b0;
      r_ram_wr <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            // rd+wr together on one index resolves to a write
            r_grant_idx <= w_idx;
            r_is_wr     <= w_sel.wr;
            r_ram_rd    <= !w_sel.wr;
            r_ram_wr    <= w_sel.wr;
            r_ram_addr  <= ADDR_W'(w_sel.addr);
            r_ram_wdata <= w_sel.wdata;
            r_ram_be    <= w_sel.be;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
            for (int i = 0; i < NUM_REQ; i++) begin
              if (w_onehot[i])
                r_starve[i] <= '0;
              else if (w_pending[i] && !w_starved[i])
                r_starve[i] <= r_starve[i] + 1'b1;
            end
          end
        end
        ISSUE: begin
          if (r_is_wr) begin
            r_ack[r_grant_idx] <= 1'b1;
            r_state            <= ACK;
          end else begin
            r_wait  <= WAIT_W'(RAM_LATENCY - 1);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_wait == '0) begin
            r_rdata[r_grant_idx] <= i_ram_rdata;
            r_ack[r_grant_idx]   <= 1'b1;
            r_state              <= ACK;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        ACK: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ack       = r_ack;
  assign o_ack_q     = r_ack_q;
  assign o_rdata     = r_rdata;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_rd    = r_ram_rd;
  assign o_ram_wr    = r_ram_wr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_ram_be    = r_ram_be;
  assign o_busy      = r_busy;
  assign o_grant_idx = r_grant_idx;

  a_no_rdwr: assert property (@(posedge i_clk) disable iff (i_reset)
    (i_req_rd & i_req_wr) == '0);
  a_req_held: assert property (@(posedge i_clk) disable iff (i_reset)
    (r_state == ISSUE || r_state == WAIT) |-> w_pending[r_grant_idx]);
  a_strobe_excl: assert property (@(posedge i_clk) disable iff (i_reset)
    !(r_ram_rd && r_ram_wr));

endmodule

// File: tb/tb_audio_ram_arbiter.sv
// Bench for audio_ram_arbiter: vector table, corner sequences,
// and randomized traffic against a RAM scoreboard.
module tb_audio_ram_arbiter;

  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        req_rd, req_wr;
  logic [2:0][12:0]  req_addr;
  logic [2:0][15:0]  req_wdata;
  logic [2:0][1:0]   req_be;
  logic [2:0]        ack, ack_q;
  logic [2:0][15:0]  rdata;
  logic [12:0]       ram_addr;
  logic              ram_rd, ram_wr;
  logic [15:0]       ram_wdata;
  logic [1:0]        ram_be;
  logic [15:0]       ram_rdata;
  logic              busy;
  logic [1:0]        grant_idx;

  int n_checks = 0;
  int n_err    = 0;

  audio_ram_arbiter #(
    .NUM_REQ(3), .ADDR_W(13), .RAM_LATENCY(LAT), .STARVE_LIMIT(8)
  ) u_dut (
    .i_clk(clk), .i_reset(reset),
    .i_req_rd(req_rd), .i_req_wr(req_wr),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .o_ack(ack), .o_ack_q(ack_q), .o_rdata(rdata),
    .o_ram_addr(ram_addr), .o_ram_rd(ram_rd), .o_ram_wr(ram_wr),
    .o_ram_wdata(ram_wdata), .o_ram_be(ram_be), .i_ram_rdata(ram_rdata),
    .o_busy(busy), .o_grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  // RAM macro model with preload port
  logic [15:0] mem [8192];
  logic [15:0] pipe [LAT];
  logic        pl_en = 1'b0;
  logic [12:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (ram_wr) begin
      if (ram_be[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
      if (ram_be[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
    end
    pipe[0] <= ram_rd ? mem[ram_addr] : 16'hDEAD;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign ram_rdata = pipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  task automatic pl(input logic [12:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
  endtask

  typedef struct {
    logic        wr;
    int          idx;
    logic [12:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    int          exp_lat;
    logic [15:0] exp_rdata;
  } vec_t;

  logic [15:0] exp_rd [3];
  logic [15:0] ref_mem [16];

  task automatic run_vec(input vec_t v);
    int lat;
    bit seen;
    logic [2:0] oh;
    oh = 3'(1 << v.idx);
    @(negedge clk);
    req_addr[v.idx]  = v.addr;
    req_wdata[v.idx] = v.wdata;
    req_be[v.idx]    = v.be;
    if (v.wr) req_wr[v.idx] = 1'b1;
    else      req_rd[v.idx] = 1'b1;
    lat = 0; seen = 1'b0;
    for (int c = 1; c <= 12 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("strobe_rd", 32'(ram_rd), 32'(!v.wr));
        chk("strobe_wr", 32'(ram_wr), 32'(v.wr));
        chk("ram_addr", 32'(ram_addr), 32'(v.addr));
        chk("grant_idx", 32'(grant_idx), 32'(v.idx));
        chk("busy_hi", 32'(busy), 32'd1);
        if (v.wr) begin
          chk("ram_wdata", 32'(ram_wdata), 32'(v.wdata));
          chk("ram_be", 32'(ram_be), 32'(v.be));
        end
      end
      if (ack != '0) begin
        seen = 1'b1;
        lat = c;
        chk("ack_vec", 32'(ack), 32'(oh));
      end
    end
    chk("ack_lat", 32'(lat), 32'(v.exp_lat));
    req_rd = '0; req_wr = '0;
    if (!v.wr) exp_rd[v.idx] = v.exp_rdata;
    for (int i = 0; i < 3; i++) chk("rdata", 32'(rdata[i]), 32'(exp_rd[i]));
    @(negedge clk);
    chk("ack_q", 32'(ack_q), 32'(oh));
    chk("ack_clr", 32'(ack), 32'd0);
    chk("busy_lo", 32'(busy), 32'd0);
  endtask

  vec_t vt [8];

  initial begin
    int q[$];
    int cnt[3];
    int n0;
    bit got;
    bit out[3];
    bit owr[3];
    logic [3:0]  oa[3];
    logic [15:0] od[3];
    logic [1:0]  ob[3];
    int age[3];

    reset = 1'b1;
    req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    for (int i = 0; i < 3; i++) exp_rd[i] = '0;

    pl(13'h1400, 16'hBEEF);
    pl(13'h0A00, 16'hAA56);
    pl(13'h0010, 16'h7700);
    pl(13'h1FFF, 16'h0000);
    for (int k = 0; k < 16; k++) begin
      ref_mem[k] = 16'($urandom);
      pl(13'h100 + 13'(k), ref_mem[k]);
    end
    @(negedge clk);
    pl_en = 1'b0;
    @(negedge clk);

    chk("rst_ack", 32'(ack), 0);
    chk("rst_ack_q", 32'(ack_q), 0);
    chk("rst_ram_rd", 32'(ram_rd), 0);
    chk("rst_ram_wr", 32'(ram_wr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdata", 32'(|rdata), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_wdata", 32'(ram_wdata), 0);
    chk("rst_be", 32'(ram_be), 0);
    chk("rst_grant", 32'(grant_idx), 0);
    reset = 1'b0;

    vt[0] = '{1'b1, 2, 13'h0A00, 16'h1234, 2'b10, 2, 16'h0};
    vt[1] = '{1'b0, 1, 13'h0A00, 16'h0,    2'b00, LAT+2, 16'h1256};
    vt[2] = '{1'b0, 0, 13'h1400, 16'h0,    2'b00, LAT+2, 16'hBEEF};
    vt[3] = '{1'b1, 1, 13'h0010, 16'hCAFE, 2'b01, 2, 16'h0};
    vt[4] = '{1'b0, 2, 13'h0010, 16'h0,    2'b00, LAT+2, 16'h77FE};
    vt[5] = '{1'b1, 0, 13'h1FFF, 16'hFFFF, 2'b11, 2, 16'h0};
    vt[6] = '{1'b0, 0, 13'h1FFF, 16'h0,    2'b00, LAT+2, 16'hFFFF};
    vt[7] = '{1'b0, 1, 13'h1400, 16'h0,    2'b00, LAT+2, 16'hBEEF};
    for (int n = 0; n < 8; n++) run_vec(vt[n]);

    // all three request in the same cycle
    @(negedge clk);
    req_addr[0] = 13'h1400; req_rd[0] = 1'b1;
    req_addr[1] = 13'h0010; req_wdata[1] = 16'hCAFE; req_be[1] = 2'b11;
    req_wr[1] = 1'b1;
    req_addr[2] = 13'h1FFF; req_rd[2] = 1'b1;
    cnt = '{0, 0, 0};
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (ack[i]) begin
        q.push_back(i);
        cnt[i]++;
        req_rd[i] = 1'b0; req_wr[i] = 1'b0;
      end
    end
    chk("sim_n_acks", 32'(q.size()), 3);
    for (int k = 0; k < 3; k++)
      chk("sim_order", (k < q.size()) ? 32'(q[k]) : 32'hFF, 32'(k));
    for (int i = 0; i < 3; i++) chk("sim_once", 32'(cnt[i]), 1);
    chk("sim_rdata0", 32'(rdata[0]), 32'hBEEF);
    chk("sim_rdata2", 32'(rdata[2]), 32'hFFFF);

    // idx0 hogs the bus while idx2 waits
    @(negedge clk);
    req_addr[0] = 13'h1400; req_rd[0] = 1'b1;
    req_addr[2] = 13'h0A00; req_wdata[2] = 16'h1234; req_be[2] = 2'b10;
    req_wr[2] = 1'b1;
    n0 = 0; got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (ack[0]) n0++;
      if (ack[2]) begin
        got = 1'b1;
        chk("starve_n0", 32'(n0), 8);
      end
    end
    if (!got) fail("starve_timeout");
    req_rd = '0; req_wr = '0;
    @(negedge clk);
    chk("starve_cnt2", 32'(u_dut.r_starve[2]), 0);
    repeat (LAT + 4) @(negedge clk);

    // reset lands while a read sits in WAIT
    req_addr[1] = 13'h1400; req_rd[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ram_rd", 32'(ram_rd), 0);
    reset = 1'b0;
    req_rd = '0;
    for (int i = 0; i < 3; i++) exp_rd[i] = '0;
    got = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ack != '0 || ack_q != '0 || ram_rd) got = 1'b1;
    end
    chk("mid_rst_quiet", 32'(got), 0);
    run_vec(vt[7]);

    // randomized traffic against the scoreboard
    for (int i = 0; i < 3; i++) begin
      out[i] = 1'b0; age[i] = 0;
    end
    for (int cyc = 0; cyc < 3400; cyc++) begin
      @(negedge clk);
      if (ram_rd && ram_wr) fail("rnd_strobe_both");
      if ($countones(ack) > 1) fail("rnd_multi_ack");
      for (int i = 0; i < 3; i++) begin
        if (ack[i]) begin
          if (!out[i]) fail("rnd_spurious_ack");
          else begin
            if (owr[i]) begin
              if (ob[i][0]) ref_mem[oa[i]][7:0]  = od[i][7:0];
              if (ob[i][1]) ref_mem[oa[i]][15:8] = od[i][15:8];
            end else begin
              chk("rnd_rdata", 32'(rdata[i]), 32'(ref_mem[oa[i]]));
            end
            out[i] = 1'b0;
            req_rd[i] = 1'b0; req_wr[i] = 1'b0;
          end
        end else if (out[i]) begin
          age[i]++;
          if (age[i] == 150) fail("rnd_ack_timeout");
        end else if (cyc < 3000 && $urandom_range(0, 2) == 0) begin
          out[i] = 1'b1; age[i] = 0;
          owr[i] = 1'($urandom_range(0, 1));
          oa[i]  = 4'($urandom_range(0, 15));
          od[i]  = 16'($urandom);
          ob[i]  = 2'($urandom_range(0, 3));
          req_addr[i]  = 13'h100 + 13'(oa[i]);
          req_wdata[i] = od[i];
          req_be[i]    = ob[i];
          if (owr[i]) req_wr[i] = 1'b1;
          else        req_rd[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 3; i++) chk("rnd_drained", 32'(out[i]), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
